des_key_sched_seq: RTL and testbench

- Sequential DES key scheduler that emits one 48-bit round subkey per handshake instead of all 16 in parallel.
- Supports the decryption direction: K16 down to K1, using right rotations. Also supports the encryption direction: K1 up to K16, using left rotations.
- Sits between key load logic and an iterative single-round DES datapath. The datapath consumes one subkey per round.

---
 rtl/des_key_sched_seq.sv | 143 ++++++++++++++
 tb/tb_des_key_sched_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/des_key_sched_seq.sv
// Sequential DES key schedule: one 48-bit subkey per valid/ready handshake,
// K1..K16 (left rotations) or K16..K1 (right rotations).
module des_key_sched_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [0:63] key,
  input  logic        decrypt,
  input  logic        abort,
  output logic [47:0] sub_key,
  output logic [3:0]  key_idx,
  output logic        sub_key_valid,
  input  logic        sub_key_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  // Table entries are 1-based DES bit numbers, output bit 1 first.
  localparam byte unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam byte unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [55:0] pc1(input logic [0:63] k);
    logic [55:0] r;
    logic [5:0]  p;
    r = '0;
    for (logic [5:0] i = 6'd0; i < 6'd56; i++) begin
      p = 6'(PC1[i] - 8'd1);
      r = {r[54:0], k[p]};
    end
    return r;
  endfunction

  // {C,D} is held with C bit 1 at cd[55]
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  p;
    r = '0;
    for (logic [5:0] i = 6'd0; i < 6'd48; i++) begin
      p = 6'(8'd56 - PC2[i]);
      r = {r[46:0], cd[p]};
    end
    return r;
  endfunction

  // Shift amount s[i+1] is 2 except for rounds 1, 2, 9 and 16
  function automatic logic two_shift(input logic [3:0] i);
    return !(i == 4'd0 || i == 4'd1 || i == 4'd8 || i == 4'd15);
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  state_t      state, state_nxt;
  logic [27:0] c_q, d_q;
  logic [3:0]  idx_q, idx_inc;
  logic        dec_q, done_q;
  logic        hs, last;
  logic [55:0] cd0;

  assign cd0     = pc1(key);
  assign idx_inc = idx_q + 4'd1;
  assign hs      = (state == RUN) && sub_key_ready;
  assign last    = dec_q ? (idx_q == 4'd0) : (idx_q == 4'd15);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start)      state_nxt = RUN;
        RUN:     if (hs && last) state_nxt = IDLE;
        default:                 state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q    <= '0;
      d_q    <= '0;
      idx_q  <= '0;
      dec_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!abort) begin
        if (state == IDLE) begin
          if (start) begin
            dec_q <= decrypt;
            if (decrypt) begin
              // C16/D16 equal C0/D0 since the rotations total 28
              c_q   <= cd0[55:28];
              d_q   <= cd0[27:0];
              idx_q <= 4'd15;
            end else begin
              c_q   <= rotl(cd0[55:28], 1'b0);
              d_q   <= rotl(cd0[27:0], 1'b0);
              idx_q <= 4'd0;
            end
          end
        end else if (hs) begin
          done_q <= last;
          if (dec_q) begin
            c_q <= rotr(c_q, two_shift(idx_q));
            d_q <= rotr(d_q, two_shift(idx_q));
            if (!last) idx_q <= idx_q - 4'd1;
          end else if (!last) begin
            idx_q <= idx_inc;
            c_q   <= rotl(c_q, two_shift(idx_inc));
            d_q   <= rotl(d_q, two_shift(idx_inc));
          end
        end
      end
    end
  end

  assign sub_key_valid = (state == RUN);
  assign busy          = (state == RUN);
  assign sub_key       = sub_key_valid ? pc2({c_q, d_q}) : 48'd0;
  assign key_idx       = idx_q;
  assign done          = done_q;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Directed bench for des_key_sched_seq against the published subkeys of key 133457799BBCDFF1.
module tb_des_key_sched_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [0:63] key = '0;
  logic        decrypt = 1'b0;
  logic        abort = 1'b0;
  logic [47:0] sub_key;
  logic [3:0]  key_idx;
  logic        sub_key_valid;
  logic        sub_key_ready = 1'b0;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

  // K1..K16 for KEY_A
  logic [47:0] ks [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  des_key_sched_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .decrypt(decrypt),
    .abort(abort), .sub_key(sub_key), .key_idx(key_idx),
    .sub_key_valid(sub_key_valid), .sub_key_ready(sub_key_ready),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one full schedule; duty = ready probability in percent,
  // poke_at = cycle at which a conflicting start is injected (-1 = none).
  task automatic run_sched(input logic [63:0] k, input logic dec, input int duty,
                           input int poke_at, input string tag);
    int          n = 0;
    int          cyc = 0;
    logic        held = 1'b0;
    logic [47:0] hk = '0;
    logic [3:0]  hi = '0;
    logic [3:0]  ei;
    logic        ok_run = 1'b1;
    key = k; decrypt = dec; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_lat"}, {63'd0, sub_key_valid}, 64'd1);
    while (n < 16 && cyc < 400) begin
      start = (cyc == poke_at);
      if (cyc == poke_at) begin key = KEY_B; decrypt = 1'b0; end
      sub_key_ready = ($urandom_range(99) < duty);
      if (!sub_key_valid || !busy || done) ok_run = 1'b0;
      if (held) begin
        chk({tag, "_hold_key"}, {16'd0, sub_key}, {16'd0, hk});
        chk({tag, "_hold_idx"}, {60'd0, key_idx}, {60'd0, hi});
      end
      if (sub_key_valid && sub_key_ready) begin
        ei = dec ? 4'(15 - n) : 4'(n);
        chk({tag, "_key"}, {16'd0, sub_key}, {16'd0, ks[ei]});
        chk({tag, "_idx"}, {60'd0, key_idx}, {60'd0, ei});
        n++;
        held = 1'b0;
      end else begin
        held = sub_key_valid;
        hk = sub_key;
        hi = key_idx;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    sub_key_ready = 1'b0;
    chk({tag, "_run_flags"}, {63'd0, ok_run}, 64'd1);
    chk({tag, "_count"}, 64'(n), 64'd16);
    chk({tag, "_done"}, {61'd0, done, sub_key_valid, busy}, 64'b100);
    tick();
    chk({tag, "_done_clr"}, {62'd0, done, sub_key_valid}, 64'd0);
  endtask

  initial begin
    logic quiet;
    #12;
    chk("reset_outs", {sub_key, key_idx, sub_key_valid, busy, done}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", {61'd0, sub_key_valid, busy, done}, 64'd0);

    run_sched(KEY_A, 1'b0, 100, -1, "enc");
    run_sched(KEY_A, 1'b1, 100, -1, "dec");
    run_sched(KEY_A, 1'b0, 30, -1, "enc_bp");
    run_sched(KEY_A, 1'b1, 30, -1, "dec_bp");
    run_sched(KEY_A, 1'b1, 100, 3, "dec_poke");
    run_sched(KEY_A ^ 64'h0101010101010101, 1'b0, 100, -1, "parity");

    // abort after five handshakes
    key = KEY_A; decrypt = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; sub_key_ready = 1'b1;
    repeat (5) tick();
    chk("abort_pre_idx", {60'd0, key_idx}, 64'd5);
    sub_key_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_outs", {61'd0, sub_key_valid, busy, done}, 64'd0);
    tick();
    chk("abort_no_done", {63'd0, done}, 64'd0);
    run_sched(KEY_A, 1'b0, 100, -1, "after_abort");

    // short asynchronous reset mid-schedule
    key = KEY_A; decrypt = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; sub_key_ready = 1'b1;
    repeat (3) tick();
    #3 rst_n = 1'b0;
    #1 chk("async_rst_outs", {sub_key, key_idx, sub_key_valid, busy, done}, 64'd0);
    #2 rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      tick();
      if (done || sub_key_valid || busy) quiet = 1'b0;
    end
    chk("post_rst_idle", {63'd0, quiet}, 64'd1);
    sub_key_ready = 1'b0;

    run_sched(KEY_A, 1'b1, 100, -1, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
